// File: rtl/noc_leaf_injector_if.sv
// Leaf-facing NoC link: one-hot VC target plus packet downstream, per-VC credit grants upstream.
interface noc_if #(
   parameter int A_W  = 4,
   parameter int D_W  = 32,
   parameter int VC_W = 2
);
   logic [VC_W-1:0]    vc_target;
   logic [A_W+D_W-1:0] packet;
   logic [VC_W-1:0]    vc_credit_gnt;

   modport transmitter (output vc_target, output packet, input vc_credit_gnt);
   modport receiver    (input vc_target, input packet, output vc_credit_gnt);
endinterface

// File: rtl/noc_leaf_injector.sv
// Client-to-leaf flit injector: 2-entry input buffer, per-VC credit counters, round-robin VC pick.
// Optional sticky credit-protocol checker enabled by defining NOC_INJECTOR_CREDIT_CHECK_EN.
module noc_leaf_injector #(
   parameter int A_W           = $clog2(8) + 1,
   parameter int D_W           = 32,
   parameter int VC_W          = 2,
   parameter int VC_FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [A_W-1:0] in_addr,
   input  logic [D_W-1:0] in_data,
   noc_if.transmitter     tx,
   output logic           credit_err
);

   localparam int P_W  = A_W + D_W;
   localparam int C_W  = $clog2(VC_FIFO_DEPTH) + 1;
   localparam int RR_W = (VC_W > 1) ? $clog2(VC_W) : 1;
   localparam logic [C_W-1:0] CMAX = C_W'(VC_FIFO_DEPTH - 1);

   logic [P_W-1:0]  mem [2];
   logic            wr_ptr, rd_ptr;
   logic [1:0]      occ, occ_nxt;
   logic            rdy_q;
   logic [C_W-1:0]  cnt [VC_W];
   logic [RR_W-1:0] rr_ptr;
   logic [VC_W-1:0] vc_target_q;
   logic [P_W-1:0]  packet_q;

   logic            push, avail, send, wr_en, rd_adv, found;
   logic [RR_W-1:0] sel, idx;
   logic [P_W-1:0]  head;

   // Ready is gated by rst so it reads 0 during reset and 1 the very first cycle after.
   assign in_ready = rdy_q & ~rst;
   assign push     = in_valid & in_ready;
   // An empty buffer forwards the incoming flit straight to the output register.
   assign head     = (occ != 2'd0) ? mem[rd_ptr] : {in_addr, in_data};
   assign avail    = (occ != 2'd0) | push;
   assign send     = avail & found;
   assign wr_en    = push & ~(send & (occ == 2'd0));
   assign rd_adv   = send & (occ != 2'd0);

   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int i = 0; i < VC_W; i++) begin
         idx = RR_W'((int'(rr_ptr) + i) % VC_W);
         if (!found && cnt[idx] != '0) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      occ_nxt = occ;
      case ({wr_en, rd_adv})
         2'b10:   occ_nxt = occ + 2'd1;
         2'b01:   occ_nxt = occ - 2'd1;
         default: occ_nxt = occ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {in_addr, in_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         occ         <= 2'd0;
         rdy_q       <= 1'b1;
         rr_ptr      <= '0;
         vc_target_q <= '0;
         packet_q    <= '0;
         for (int v = 0; v < VC_W; v++) cnt[v] <= CMAX;
      end else begin
         if (wr_en)  wr_ptr <= ~wr_ptr;
         if (rd_adv) rd_ptr <= ~rd_ptr;
         occ   <= occ_nxt;
         rdy_q <= (occ_nxt != 2'd2);
         vc_target_q <= '0;
         if (send) begin
            vc_target_q <= VC_W'(1) << sel;
            packet_q    <= head;
            rr_ptr      <= RR_W'((int'(sel) + 1) % VC_W);
         end
         // A same-cycle send and grant on one VC cancel; grants saturate at full credit.
         for (int v = 0; v < VC_W; v++) begin
            if ((send && sel == RR_W'(v)) && !tx.vc_credit_gnt[v])
               cnt[v] <= cnt[v] - C_W'(1);
            else if (!(send && sel == RR_W'(v)) && tx.vc_credit_gnt[v] && cnt[v] != CMAX)
               cnt[v] <= cnt[v] + C_W'(1);
         end
      end
   end

   assign tx.vc_target = vc_target_q;
   assign tx.packet    = packet_q;

`ifdef NOC_INJECTOR_CREDIT_CHECK_EN
   logic err_set, err_q;

   always_comb begin
      err_set = send && (cnt[sel] == '0);
      for (int v = 0; v < VC_W; v++)
         if (tx.vc_credit_gnt[v] && cnt[v] == CMAX) err_set = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)          err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end

   assign credit_err = err_q;
`else
   assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_leaf_injector.sv
// Randomized + directed bench for noc_leaf_injector against a queue/credit reference model.
module tb_noc_leaf_injector;

   localparam int MAXC = 3;
`ifdef NOC_INJECTOR_CREDIT_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_addr = '0;
   logic [31:0] in_data = '0;
   logic        credit_err;

   noc_if #(.A_W(4), .D_W(32), .VC_W(2)) txif ();

   noc_leaf_injector #(.A_W(4), .D_W(32), .VC_W(2), .VC_FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_addr    (in_addr),
      .in_data    (in_data),
      .tx         (txif.transmitter),
      .credit_err (credit_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [35:0] q[$];
   int          cred [2];
   int          rr;
   logic [1:0]  exp_tgt;
   logic [35:0] exp_pkt;
   logic        exp_rdy;
   logic        exp_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      cred[0] = MAXC;
      cred[1] = MAXC;
      rr      = 0;
      exp_tgt = 2'b00;
      exp_pkt = '0;
      exp_rdy = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic model_cycle(input logic v, input logic [35:0] f, input logic [1:0] g);
      bit sent = 0;
      int vs = 0;
      for (int w = 0; w < 2; w++)
         if (g[w] && cred[w] == MAXC && ERR_EN) exp_err = 1'b1;
      if (v && exp_rdy) q.push_back(f);
      if (q.size() > 0)
         for (int k = 0; k < 2; k++)
            if (!sent && cred[(rr + k) % 2] > 0) begin
               sent = 1;
               vs   = (rr + k) % 2;
            end
      if (sent) begin
         exp_pkt = q.pop_front();
         exp_tgt = 2'(1 << vs);
         cred[vs]--;
         rr = (vs + 1) % 2;
      end else begin
         exp_tgt = 2'b00;
      end
      for (int w = 0; w < 2; w++)
         if (g[w]) cred[w] = (cred[w] + 1 > MAXC) ? MAXC : cred[w] + 1;
      exp_rdy = (q.size() < 2);
   endtask

   task automatic compare_all();
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("vc_target", 64'(txif.vc_target), 64'(exp_tgt));
      check("packet", 64'(txif.packet), 64'(exp_pkt));
      check("credit_err", 64'(credit_err), 64'(exp_err));
   endtask

   task automatic step(input logic v, input logic [3:0] a, input logic [31:0] d, input logic [1:0] g);
      in_valid = v;
      in_addr  = a;
      in_data  = d;
      txif.vc_credit_gnt = g;
      @(posedge clk);
      model_cycle(v, {a, d}, g);
      #1;
      compare_all();
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b1;
      in_valid = 1'($urandom);
      in_data  = $urandom;
      txif.vc_credit_gnt = 2'($urandom);
      repeat (n) @(posedge clk);
      #1;
      model_reset();
      compare_all();
      rst      = 1'b0;
      in_valid = 1'b0;
      txif.vc_credit_gnt = 2'b00;
      #1;
      exp_rdy = 1'b1;
      check("rdy_after_rst", 64'(in_ready), 64'd1);
   endtask

   int sends;

   initial begin
      txif.vc_credit_gnt = 2'b00;
      model_reset();
      do_reset(3);

      // Single flit, bypass latency
      step(1'b1, 4'h5, 32'hA5A5_0001, 2'b00);
      check("first_tgt", 64'(txif.vc_target), 64'h1);
      check("first_pkt", 64'(txif.packet), 64'({4'h5, 32'hA5A5_0001}));
      step(1'b0, 4'h0, 32'h0, 2'b00);
      check("idle_tgt", 64'(txif.vc_target), 64'h0);

      // Eight back-to-back flits against six credits
      do_reset(2);
      sends = 0;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 4'(i), $urandom, 2'b00);
         if (txif.vc_target != 2'b00) sends++;
      end
      step(1'b0, 4'h0, 32'h0, 2'b00);
      if (txif.vc_target != 2'b00) sends++;
      check("burst_sends", 64'(sends), 64'd6);
      check("burst_rdy_low", 64'(in_ready), 64'd0);

      // One credit back on VC1
      step(1'b0, 4'h0, 32'h0, 2'b10);
      step(1'b0, 4'h0, 32'h0, 2'b00);
      check("gnt1_send", 64'(txif.vc_target), 64'h2);
      step(1'b0, 4'h0, 32'h0, 2'b00);
      check("gnt1_hold", 64'(txif.vc_target), 64'h0);

      // Reset with buffered flits and no credit
      step(1'b1, 4'h9, 32'h1234_5678, 2'b00);
      check("full_rdy_low", 64'(in_ready), 64'd0);
      do_reset(2);
      step(1'b1, 4'h3, 32'hCAFE_0003, 2'b00);
      check("post_rst_tgt", 64'(txif.vc_target), 64'h1);
      check("post_rst_pkt", 64'(txif.packet), 64'({4'h3, 32'hCAFE_0003}));

      // Send and grant on VC0 with one credit left
      for (int i = 0; i < 3; i++) step(1'b1, 4'(i), $urandom, 2'b00);
      step(1'b1, 4'hA, 32'h0000_00A0, 2'b01);
      check("same_cyc_tgt", 64'(txif.vc_target), 64'h1);
      step(1'b1, 4'hB, 32'h0000_00B0, 2'b00);
      step(1'b1, 4'hC, 32'h0000_00C0, 2'b00);
      check("vc0_credit_kept", 64'(txif.vc_target), 64'h1);

      // Grant on a full counter
      do_reset(2);
      step(1'b0, 4'h0, 32'h0, 2'b10);
      check("err_set", 64'(credit_err), 64'(ERR_EN));
      step(1'b0, 4'h0, 32'h0, 2'b00);
      step(1'b0, 4'h0, 32'h0, 2'b00);
      check("err_sticky", 64'(credit_err), 64'(ERR_EN));
      do_reset(1);
      check("err_cleared", 64'(credit_err), 64'd0);

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(99) == 0) do_reset(1 + $urandom_range(1));
         else step($urandom_range(9) < 7, 4'($urandom), $urandom,
                   {$urandom_range(3) == 0, $urandom_range(3) == 0});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_leaf_injector.md
NOC_LEAF_INJECTOR -- requirements
Module: noc_leaf_injector

Interface
REQ-001 Parameter A_W, default $clog2(DEFAULT_N)+1; destination address width, equal to the topology's A_W.
REQ-002 Parameter D_W, default DEFAULT_D_W; payload width.
REQ-003 Parameter VC_W, default DEFAULT_VC_W; number of virtual channels (one-hot bit per VC).
REQ-004 Parameter VC_FIFO_DEPTH, default DEFAULT_VC_FIFO_DEPTH; downstream per-VC FIFO parameter; usable credits = VC_FIFO_DEPTH-1.
REQ-005 clk  input  1  sole clock; all logic rising-edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  client flit offered.
REQ-008 in_ready  output  1  injector can accept a flit this cycle.
REQ-009 in_addr  input  A_W  destination leaf address.
REQ-010 in_data  input  D_W  payload.
REQ-011 tx  noc_if.transmitter  (vc_target VC_W out, packet A_W+D_W out, vc_credit_gnt VC_W in)  leaf-facing link into a tree leaf_rx port.
REQ-012 credit_err  output  1  sticky credit-protocol error flag (see Configuration).

Function
REQ-013 Client transfer occurs on any cycle with in_valid && in_ready; in_addr/in_data captured that cycle.
REQ-014 Input buffer: 2-entry FIFO; in_ready = (occupancy < 2), registered, independent of in_valid.
REQ-015 Per-VC credit counter, width $clog2(VC_FIFO_DEPTH)+1, range 0..VC_FIFO_DEPTH-1.
REQ-016 Send condition per cycle: buffer non-empty AND at least one VC with credit > 0.
REQ-017 VC selection: round-robin among VCs with credit > 0, starting at rr_ptr; rr_ptr advances to selected VC+1 (mod VC_W) after each send.
REQ-018 On send: tx.vc_target registered one-hot of selected VC for exactly one cycle; tx.packet registered {in_addr, in_data} of the buffer head; head popped same cycle.
REQ-019 tx.vc_target = 0 on all non-send cycles; tx.packet holds last value (don't-care when vc_target = 0).
REQ-020 At most one flit per cycle; sustained throughput 1 flit/cycle while credits available.
REQ-021 Latency: flit accepted at cycle t into an empty buffer with credit available appears on tx at cycle t+1 (write-bypass into output register); otherwise in FIFO order.
REQ-022 tx.vc_credit_gnt[v] high for one cycle returns one credit to VC v; counter value visible to selection next cycle.
REQ-023 Simultaneous send and credit return on the same VC in one cycle: counter unchanged.
REQ-024 Credit return on multiple VCs in one cycle: each counter incremented independently.
REQ-025 Credit return with counter already at VC_FIFO_DEPTH-1: counter saturates (no wrap).
REQ-026 All VCs at zero credit: no send, head flit held, in_ready falls once buffer reaches 2 entries.
REQ-027 Simultaneous push and pop with buffer full: push accepted only if in_ready was high that cycle; occupancy never exceeds 2.

Reset
REQ-028 While rst is high: buffer emptied, in_ready = 0, tx.vc_target = 0, tx.packet = 0, rr_ptr = 0, credit_err = 0, every credit counter = VC_FIFO_DEPTH-1.
REQ-029 First cycle after rst deasserts: in_ready = 1.
REQ-030 Reset mid-operation discards buffered flits and restores full credit; vc_credit_gnt pulses during reset are ignored.

Configuration
REQ-031 Macro NOC_INJECTOR_CREDIT_CHECK_EN defined: credit_err sets (sticky until rst) on a credit return to a counter already at VC_FIFO_DEPTH-1, or on any send attempted with zero credit.
REQ-032 Macro undefined: credit_err tied to 0; saturation behaviour of REQ-025 unchanged.

Verification (VC_W=2, VC_FIFO_DEPTH=4, A_W=4, D_W=32)
REQ-033 After reset, push 1 flit addr=5 data=0xA5A5_0001, no gnts -> vc_target=2'b01 one cycle later, packet={4'h5,32'hA5A5_0001}.
REQ-034 Push 8 back-to-back flits, no gnts -> 6 sends alternating VC0,VC1,VC0..., then vc_target=0, in_ready low with 2 flits buffered.
REQ-035 From REQ-034 state, pulse vc_credit_gnt=2'b10 once -> exactly one send on VC1 the cycle after the pulse; next buffered flit waits.
REQ-036 VC0 credit=1, same cycle send on VC0 and gnt[0] -> VC0 credit stays 1, next send on VC0 allowed.
REQ-037 With macro defined, gnt[1] after reset (counter full) -> credit_err=1 and held until rst; without macro -> credit_err=0.
REQ-038 Assert rst with 2 flits buffered and zero credits -> after release in_ready=1, vc_target=0, new flit sent next cycle on VC0.
